ccc_clken_gen: RTL



---
 rtl/ccc_pkg.sv | 15 +
 rtl/ccc_clken_chan.sv | 58 +++++
 rtl/ccc_clken_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/ccc_pkg.sv
// Shared types and constants for the lock-qualified
// clock-enable generator.
package ccc_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    QUALIFY,
    RUN
  } ccc_state_e;

  localparam int LOSS_CNT_W      = 8;
  localparam int DEF_LOCK_FILTER = 64;
  localparam int DEF_LOSS_FILTER = 4;

endpackage

// File: rtl/ccc_clken_chan.sv
// One enable channel: active/pending divisor and
// free-running phase counter.
module ccc_clken_chan #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  output logic             clken
);

  localparam logic [DIV_W-1:0] ONE = 1;

  logic [DIV_W-1:0] a;
  logic [DIV_W-1:0] p;
  logic [DIV_W-1:0] c;
  logic [DIV_W-1:0] eff;
  logic             pv;
  logic             wrap;

  assign eff  = (a == '0) ? ONE : a;
  assign wrap = (c >= eff - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= ONE;
      p     <= '0;
      pv    <= 1'b0;
      c     <= '0;
      clken <= 1'b0;
    end else begin
      if (run && en) begin
        clken <= (c == '0);
        c     <= wrap ? '0 : c + ONE;
        if (wrap && pv) begin
          a  <= p;
          pv <= 1'b0;
        end
      end else begin
        clken <= 1'b0;
        c     <= '0;
        if (pv) begin
          a  <= p;
          pv <= 1'b0;
        end
      end
      // a fresh load always wins over an apply in the same cycle
      if (load) begin
        p  <= div;
        pv <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccc_clken_gen.sv
// Lock synchroniser, qualify/loss filters and the
// per-channel enable array.
module ccc_clken_gen
  import ccc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_FILTER = DEF_LOCK_FILTER,
  parameter int LOSS_FILTER = DEF_LOSS_FILTER
) (
  input  logic                      FAB_CLK,
  input  logic                      FAB_RST,
  input  logic                      FAB_LOCK,
  input  logic [CHANNELS*DIV_W-1:0] DIV,
  input  logic [CHANNELS-1:0]       DIV_LOAD,
  input  logic [CHANNELS-1:0]       CH_EN,
  input  logic                      LOCK_LOST_CLR,
  output logic [CHANNELS-1:0]       CLKEN,
  output logic                      LOCKED,
  output logic                      LOCK_LOST,
  output logic [LOSS_CNT_W-1:0]     LOSS_CNT
);

  localparam int QW = $clog2(LOCK_FILTER + 1);
  localparam int ZW = $clog2(LOSS_FILTER + 1);

  ccc_state_e     state;
  logic           sync1;
  logic           lock_s;
  logic [QW-1:0]  q;
  logic [ZW-1:0]  z;
  logic           loss;
  logic           run_nxt;

  assign loss = (state == RUN) && !lock_s &&
                (z == ZW'(LOSS_FILTER - 1));

  // channels see RUN on the same edge the FSM enters it
  always_comb begin
    run_nxt = 1'b0;
    unique case (state)
      UNLOCKED: run_nxt = 1'b0;
      QUALIFY:  run_nxt = lock_s && (q == QW'(LOCK_FILTER));
      RUN:      run_nxt = !loss;
      default:  run_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RST) begin
      state     <= UNLOCKED;
      sync1     <= 1'b0;
      lock_s    <= 1'b0;
      q         <= '0;
      z         <= '0;
      LOCKED    <= 1'b0;
      LOCK_LOST <= 1'b0;
      LOSS_CNT  <= '0;
    end else begin
      sync1  <= FAB_LOCK;
      lock_s <= sync1;
      LOCKED <= run_nxt;
      unique case (state)
        UNLOCKED: begin
          if (lock_s) begin
            state <= QUALIFY;
            q     <= QW'(1);
          end
        end
        QUALIFY: begin
          if (!lock_s) begin
            state <= UNLOCKED;
            q     <= '0;
          end else if (q == QW'(LOCK_FILTER)) begin
            state <= RUN;
            q     <= '0;
            z     <= '0;
          end else begin
            q <= q + QW'(1);
          end
        end
        RUN: begin
          if (lock_s) begin
            z <= '0;
          end else if (loss) begin
            state <= UNLOCKED;
            z     <= '0;
          end else begin
            z <= z + ZW'(1);
          end
        end
        default: state <= UNLOCKED;
      endcase
      if (loss) begin
        LOCK_LOST <= 1'b1;
      end else if (LOCK_LOST_CLR) begin
        LOCK_LOST <= 1'b0;
      end
      if (loss && (LOSS_CNT != '1)) begin
        LOSS_CNT <= LOSS_CNT + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    ccc_clken_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .clk  (FAB_CLK),
      .rst  (FAB_RST),
      .run  (run_nxt),
      .en   (CH_EN[i]),
      .div  (DIV[i*DIV_W +: DIV_W]),
      .load (DIV_LOAD[i]),
      .clken(CLKEN[i])
    );
  end

endmodule
